apb_slave_mem: RTL and testbench

- APB3 completer (slave) sitting directly downstream of the testbench APB bus.
- Consumes PSELx/PENABLE/PWRITE/PADDR/PWDATA and produces PRDATA/PREADY/PSLVERR.
- Backs a word-addressed register memory and inserts programmable wait states.
- Reports errors on out-of-range or misaligned accesses. Serves as the DUT the APB driver and monitor exercise.

---
 rtl/apb_slave_mem_if.sv | 23 ++
 rtl/apb_slave_mem.sv | 172 +++++++++++++++++
 tb/tb_apb_slave_mem.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB3 bus bundle between a requester and the apb_slave_mem completer.
// The master modport drives select/enable/address/data; the slave modport returns
// read data, ready and error.
interface apb_slave_mem_if;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a DEPTH x 32-bit word memory.
// Transfers are captured in the setup phase; PREADY, PSLVERR and PRDATA are
// registered and valid for exactly one cycle. Out-of-range or misaligned
// addresses complete with PSLVERR and leave memory untouched.
// Optional feature, macro APB_SLV_WAIT_EN: when defined, WAIT_CYCLES wait
// states are inserted per transfer; when undefined the slave is zero-wait-state
// and the wait counter does not exist.
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_slave_mem_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_slave_mem: DEPTH must be a power of 2 and at least 2");
    end
    if ((BASE_ADDR % (4 * DEPTH)) != 0) begin : g_bad_base
        $error("apb_slave_mem: BASE_ADDR must be aligned to 4*DEPTH");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_slave_mem: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q;
    logic            write_q;
    logic            valid_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [31:0]     mem [DEPTH];

`ifdef APB_SLV_WAIT_EN
    logic [3:0]      cnt_q, cnt_d;
`endif

    logic            setup;
    logic            load;
    logic            setup_valid;
    logic [AW-1:0]   setup_idx;
    logic            commit;
    logic            cur_valid;
    logic            cur_write;
    logic [AW-1:0]   cur_idx;
    logic [31:0]     read_word;

    assign setup = bus.PSELx && !bus.PENABLE;

    // Range check done in 33 bits so a window ending at 4 GiB cannot wrap.
    assign setup_valid = ({1'b0, bus.PADDR} >= {1'b0, BASE_ADDR}) &&
                         ({1'b0, bus.PADDR} <  END_ADDR) &&
                         (bus.PADDR[1:0] == 2'b00);

    // BASE_ADDR is aligned to 4*DEPTH, so the word index is simply the low
    // address bits above the byte offset.
    assign setup_idx = bus.PADDR[AW+1:2];

    // A valid write retires on the edge that ends its DONE cycle.
    assign commit = (state_q == DONE) && write_q && valid_q;

    // Next-state logic: capture in setup, count wait states, abort on deselect.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        load    = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (setup) begin
                    load = 1'b1;
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? DONE : ACCESS;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
`ifdef APB_SLV_WAIT_EN
                if (!bus.PSELx) begin
                    state_d = IDLE;
                end else if (bus.PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Response for the cycle about to start; forwards a write retiring this edge.
    always_comb begin
        cur_valid = load ? setup_valid : valid_q;
        cur_write = load ? bus.PWRITE  : write_q;
        cur_idx   = load ? setup_idx   : idx_q;
        read_word = (commit && (idx_q == cur_idx)) ? wdata_q : mem[cur_idx];
        ready_d   = (state_d == DONE);
        err_d     = ready_d && !cur_valid;
        rdata_d   = (ready_d && cur_valid && !cur_write) ? read_word : 32'h0;
    end

    // State, latched transfer context and registered bus outputs.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (PRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
            if (load) begin
                idx_q   <= setup_idx;
                write_q <= bus.PWRITE;
                wdata_q <= bus.PWDATA;
                valid_q <= setup_valid;
            end
        end
    end

    // Word memory: cleared by reset, updated when a valid write completes.
    always_ff @(posedge PCLK) begin
        // NOTE: reset must clear every word, so the memory is a resettable flop array rather than a RAM macro.
        if (PRESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.PRDATA  = rdata_q;
    assign bus.PREADY  = ready_q;
    assign bus.PSLVERR = err_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed plus random APB3 traffic against apb_slave_mem.
// The driver pushes the expected completion (cycle, PSLVERR, PRDATA) of each
// transfer into a queue; a negedge monitor pops and compares on every PREADY.
module tb_apb_slave_mem;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef APB_SLV_WAIT_EN
    localparam int          W     = 2;
`else
    localparam int          W     = 0;
`endif

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          checks;
    int          errors;
    bit          mon_en;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];

    apb_slave_mem_if bus ();

    apb_slave_mem #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (2)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference address map: byte window [BASE, BASE+4*DEPTH), word aligned.
    function automatic bit addr_ok(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH) && (la % 4 == 0);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // Monitor: every cycle with PREADY consumes one expectation; otherwise outputs must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.PREADY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_cycle"},   32'(cyc),    32'(mon_e.cyc));
                    check({mon_e.name, "_pslverr"}, bus.PSLVERR, mon_e.err);
                    check({mon_e.name, "_prdata"},  bus.PRDATA,  mon_e.data);
                end
            end else begin
                check("idle_pready",  bus.PREADY,  1'b0);
                check("idle_pslverr", bus.PSLVERR, 1'b0);
                check("idle_prdata",  bus.PRDATA,  32'h0);
            end
        end
    end

    // Drive a setup phase and record what the transfer must return, unless it will be aborted.
    task automatic setup_phase(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                               input int abort_k, input string name);
        exp_t e;
        bit   ok;
        bus.PSELx   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = addr;
        bus.PWRITE  = wr;
        bus.PWDATA  = wd;
        if (!(abort_k != 0 && abort_k <= W)) begin
            ok     = addr_ok(addr);
            e.cyc  = cyc + 1 + W;
            e.err  = !ok;
            e.data = (ok && !wr) ? model[addr_idx(addr)] : 32'h0;
            e.name = name;
            if (ok && wr) model[addr_idx(addr)] = wd;
            exp_q.push_back(e);
        end
    endtask

    // Access phase: hold PENABLE until PREADY, or drop PSELx in access cycle abort_k.
    task automatic access_phase(input int abort_k);
        bit fin;
        fin = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            if (i == abort_k) bus.PSELx = 1'b0;
            @(negedge clk);
            if (bus.PREADY === 1'b1) begin
                fin = 1'b1;
                break;
            end
            if (i == abort_k) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!fin) check("pready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int abort_k, input string name);
        setup_phase(addr, wr, wd, abort_k, name);
        access_phase(abort_k);
    endtask

    // Second transfer's setup is presented in the first transfer's PREADY cycle.
    task automatic xfer_chain(input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                              input logic [31:0] a2, input logic w2, input logic [31:0] d2);
        setup_phase(a1, w1, d1, 0, "chain_first");
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        repeat (W) begin
            @(posedge clk); #1;
        end
        setup_phase(a2, w2, d2, 0, "chain_second");
        access_phase(0);
    endtask

    task automatic idle(input int n);
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pready"},  bus.PREADY,  1'b0);
        check({name, "_pslverr"}, bus.PSLVERR, 1'b0);
        check({name, "_prdata"},  bus.PRDATA,  32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] wd;
        logic        wr;
        int          ab;
        int          gap;

        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        rst         = 1'b1;
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 32'h0;
        bus.PWDATA  = 32'h0;

        // Reset for two cycles, outputs must be zero.
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        xfer(32'h00, 1'b0, 32'h0, 0, "rd00_after_reset");

        // Write then read back, completion cycle checked by the scoreboard.
        idle(1);
        xfer(32'h08, 1'b1, 32'hDEAD_BEEF, 0, "wr08");
        idle(1);
        xfer(32'h08, 1'b0, 32'h0, 0, "rd08");

        // Back-to-back with no idle cycle, top word.
        xfer(32'h3C, 1'b1, 32'h1111_1111, 0, "wr3c");
        xfer(32'h3C, 1'b0, 32'h0, 0, "rd3c");

        // Errors: out of range read, misaligned write, memory unchanged.
        xfer(32'h04, 1'b1, 32'h0404_0404, 0, "wr04");
        xfer(32'h40, 1'b0, 32'h0, 0, "rd40_range");
        xfer(32'h06, 1'b1, 32'hFFFF_FFFF, 0, "wr06_misaligned");
        xfer(32'h04, 1'b0, 32'h0, 0, "rd04");

        // Master abort in the second access cycle.
        idle(1);
        xfer(32'h10, 1'b1, 32'hA5A5_A5A5, 2, "wr10_abort");
        idle(1);
        xfer(32'h10, 1'b0, 32'h0, 0, "rd10");

        // Setup sampled in the PREADY cycle: read-after-write through the retiring write.
        idle(1);
        xfer_chain(32'h20, 1'b1, 32'h1234_5678, 32'h20, 1'b0, 32'h0);
        idle(1);

        // Reset in the first access cycle of a write to 0x0C.
        setup_phase(32'h0C, 1'b1, 32'hC0C0_C0C0, 1, "wr0c_reset");
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        idle(1);
        xfer(32'h0C, 1'b0, 32'h0, 0, "rd0c_after_reset");
        xfer(32'h08, 1'b0, 32'h0, 0, "rd08_after_reset");

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                3:       addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
                4:       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                5:       addr = BASE + 32'(4 * DEPTH - 4);
                6:       addr = 32'hFFFF_FFFC;
                default: addr = BASE;
            endcase
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 7) == 0) begin
                xfer_chain(addr, 1'b1, wd, addr, 1'b0, 32'h0);
            end else begin
                xfer(addr, wr, wd, ab, "rand");
            end
            gap = int'($urandom_range(0, 2));
            if (gap != 0) idle(gap);
        end

        idle(4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
